// File: rtl/arcade_pkg.sv
// Shared arcade constants: button indices, channel count and 50 MHz timing
// defaults for the button front end, plus the per-channel debounce state type.
package arcade_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;

    localparam int N_BTN_DEFAULT = 5;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
    localparam int DEBOUNCE_CYCLES_50MHZ = 500_000;
    localparam int REPEAT_DELAY_50MHZ    = 25_000_000;
    localparam int REPEAT_PERIOD_50MHZ   = 5_000_000;

    // Only the horizontal controls auto-repeat
    localparam logic [N_BTN_DEFAULT-1:0] REPEAT_MASK_DEFAULT =
        N_BTN_DEFAULT'((1 << BTN_LEFT) | (1 << BTN_RIGHT));

    // Bit 1 of the encoding is the debounced level, so it can drive the
    // output straight from a flop.
    typedef enum logic [1:0] {
        ST_RELEASED     = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } btn_state_e;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the conditioner outputs.
// master: pin side / consumer, slave: the conditioner itself.
interface btn_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic             any_level;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  any_level
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output any_level
    );
endinterface

// File: rtl/btn_conditioner_channel.sv
// One button channel: two-flop synchronizer, debounce FSM and, when
// BTN_AUTOREPEAT_EN is defined, an auto-repeat timer for masked channels.
//
// state         | meaning
// --------------+---------------------------------------------------------
// RELEASED      | level 0, synchronized input agrees
// PRESS_WAIT    | level 0, input high, counting towards acceptance
// PRESSED       | level 1, input agrees, repeat timer running
// RELEASE_WAIT  | level 1, input low, counting towards release
module btn_channel
    import arcade_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_50MHZ,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_50MHZ,
    parameter bit REPEAT_EN     = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_btn_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pulse;
    logic             w_level;
    logic             w_cnt_last;
    logic             w_press;
    logic             w_rep_fire;

    // Plain two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level    = r_state[1];
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Debounce state, stability counter and output strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_press | w_rep_fire;
        end
    end

    // Next state: any sample agreeing with the level restarts the count
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_press     = 1'b0;
        if ((r_sync2 != w_level) && !w_cnt_last) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        case (r_state)
            ST_RELEASED: begin
                if (r_sync2) w_state_nxt = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_RELEASED;
                end else if (w_cnt_last) begin
                    w_state_nxt = ST_PRESSED;
                    w_press     = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!r_sync2) w_state_nxt = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = ST_PRESSED;
                end else if (w_cnt_last) begin
                    w_state_nxt = ST_RELEASED;
                end
            end
            default: w_state_nxt = ST_RELEASED;
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int REP_W   = $clog2(REP_MAX + 1);

        logic [REP_W-1:0] r_rep;
        logic [REP_W-1:0] w_rep_nxt;

        // Down-counter: loaded on every entry to PRESSED, cleared otherwise
        always_comb begin
            w_rep_nxt = '0;
            if (w_state_nxt == ST_PRESSED) begin
                if (r_state != ST_PRESSED) begin
                    w_rep_nxt = REP_W'(REPEAT_DELAY - 1);
                end else if (r_rep == '0) begin
                    w_rep_nxt = REP_W'(REPEAT_PERIOD - 1);
                end else begin
                    w_rep_nxt = r_rep - 1'b1;
                end
            end
        end

        assign w_rep_fire = (r_state == ST_PRESSED) && (r_rep == '0);

        // Repeat timer register
        always_ff @(posedge clk) begin
            if (rst) r_rep <= '0;
            else     r_rep <= w_rep_nxt;
        end
    end else begin : g_no_repeat
        assign w_rep_fire = 1'b0;
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign o_btn_level = w_level;
    assign o_btn_pulse = r_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: N_BTN independent debounce channels plus any_level.
// Auto-repeat on masked channels is built only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
    import arcade_pkg::*;
#(
    parameter int               N_BTN           = N_BTN_DEFAULT,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_50MHZ,
    parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_50MHZ,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEFAULT)
) (
    input logic               clk,
    input logic               rst,
    btn_conditioner_if.slave  bus
);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_pulse;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
`endif
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_btn_raw   (bus.btn_raw[i]),
            .o_btn_level (w_level[i]),
            .o_btn_pulse (w_pulse[i])
        );
    end

`ifndef BTN_AUTOREPEAT_EN
    // Repeat settings have no effect in this build; the empty block keeps
    // them referenced so the parameter list stays identical across builds.
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0 || REPEAT_MASK == '0) begin : g_repeat_cfg_unused
    end
`endif

    assign bus.btn_level = w_level;
    assign bus.btn_pulse = w_pulse;
    assign bus.any_level = |w_level;

endmodule
